// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//
// Bundles the two writeback request channels, the register-file write port
// and the hazard/status outputs of regfile_write_arbiter.
//
//   req0_valid/addr/data, req0_ready : ALU / immediate writeback channel
//   req1_valid/addr/data, req1_ready : load / multi-cycle-unit writeback channel
//   wr_en, wr_addr, wr_data          : register-file write port (registered)
//   pending                          : registers with a write still in flight
//   conflict_cnt                     : saturating count of both-buffers-full cycles
//
// master : the writeback requesters (and whatever observes the write port)
// slave  : the arbiter itself
interface regfile_write_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;

    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] pending;
    logic [15:0] conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data,
        input  pending, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data,
        output pending, conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the register file's single write port between two writeback
// requesters. Each requester owns a one-entry holding buffer; an age-ordered
// arbiter with a round-robin tie-break picks one buffer per cycle and loads
// it into the registered write port. Because wr_* only change on the rising
// edge, a register file that writes on the falling edge sees stable values.
//
// Ports:
//   clock   : system clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : regfile_write_arbiter_if.slave (request channels, write port,
//             pending bitmap, conflict counter)
module regfile_write_arbiter (
    input  logic                    clock,
    input  logic                    reset_n,
    regfile_write_arbiter_if.slave  bus
);

    // Holding buffers, one per requester.
    logic        hold0_valid, hold1_valid;
    logic [4:0]  hold0_addr, hold1_addr;
    logic [31:0] hold0_data, hold1_data;
    logic [3:0]  hold0_age, hold1_age;

    // Sequence stamp handed to every capture. A held entry is always granted
    // within two cycles, so two live stamps are never more than one apart and
    // a 4-bit wrapping counter compared by signed difference is plenty.
    logic [3:0]  seq;
    logic        rr_ptr;

    logic        grant0, grant1, tie;
    logic [3:0]  age_diff;
    logic        take0, take1;
    logic        ready0, ready1;

    logic        wr_en_q;
    logic [4:0]  wr_addr_q;
    logic [31:0] wr_data_q;
    logic [15:0] conflict_q;
    logic [31:0] pending_c;

    // Arbitration over the valid holds: a lone hold wins, otherwise the
    // older stamp wins, and equal stamps fall back to the round-robin pointer.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        tie      = 1'b0;
        age_diff = hold0_age - hold1_age;
        if (hold0_valid && hold1_valid) begin
            if (age_diff == 4'd0) begin
                tie = 1'b1;
                if (rr_ptr) begin
                    grant1 = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else if (age_diff[3]) begin
                // Negative difference: hold0 was stamped first.
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else if (hold0_valid) begin
            grant0 = 1'b1;
        end else if (hold1_valid) begin
            grant1 = 1'b1;
        end
    end

    // A buffer can accept when empty or when it is being drained this cycle,
    // which lets an uncontended requester stream one write per cycle.
    assign ready0 = !hold0_valid || grant0;
    assign ready1 = !hold1_valid || grant1;
    assign take0  = bus.req0_valid && ready0;
    assign take1  = bus.req1_valid && ready1;

    // Holding buffer 0: a capture wins over the free so that a simultaneous
    // drain-and-refill keeps the new entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold0_valid <= 1'b0;
            hold0_addr  <= 5'd0;
            hold0_data  <= 32'd0;
            hold0_age   <= 4'd0;
        end else if (take0) begin
            hold0_valid <= 1'b1;
            hold0_addr  <= bus.req0_addr;
            hold0_data  <= bus.req0_data;
            hold0_age   <= seq;
        end else if (grant0) begin
            hold0_valid <= 1'b0;
        end
    end

    // Holding buffer 1, same behaviour as buffer 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold1_valid <= 1'b0;
            hold1_addr  <= 5'd0;
            hold1_data  <= 32'd0;
            hold1_age   <= 4'd0;
        end else if (take1) begin
            hold1_valid <= 1'b1;
            hold1_addr  <= bus.req1_addr;
            hold1_data  <= bus.req1_data;
            hold1_age   <= seq;
        end else if (grant1) begin
            hold1_valid <= 1'b0;
        end
    end

    // Stamp counter advances once per capturing edge, so two captures on the
    // same edge share a stamp and are treated as a tie. The round-robin
    // pointer only moves when it actually decided a tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seq    <= 4'd0;
            rr_ptr <= 1'b0;
        end else begin
            if (take0 || take1) begin
                seq <= seq + 4'd1;
            end
            if (tie) begin
                rr_ptr <= ~rr_ptr;
            end
        end
    end

    // Registered write port. Writes to r0 still occupy their output slot but
    // keep wr_en low; with no grant the address and data simply hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else if (grant0) begin
            wr_en_q   <= (hold0_addr != 5'd0);
            wr_addr_q <= hold0_addr;
            wr_data_q <= hold0_data;
        end else if (grant1) begin
            wr_en_q   <= (hold1_addr != 5'd0);
            wr_addr_q <= hold1_addr;
            wr_data_q <= hold1_data;
        end else begin
            wr_en_q   <= 1'b0;
        end
    end

    // Count edges on which both buffers were occupied, sticking at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= 16'd0;
        end else if (hold0_valid && hold1_valid && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    // Pending bitmap: every register named by a live hold or by the write
    // currently presented. r0 is never reported since it is never written.
    always_comb begin
        pending_c = 32'd0;
        if (hold0_valid) begin
            pending_c[hold0_addr] = 1'b1;
        end
        if (hold1_valid) begin
            pending_c[hold1_addr] = 1'b1;
        end
        if (wr_en_q) begin
            pending_c[wr_addr_q] = 1'b1;
        end
        pending_c[0] = 1'b0;
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.pending      = pending_c;
    assign bus.conflict_cnt = conflict_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter: reset values, a table of
// hand-derived cycle vectors, a mid-stream reset, counter saturation under
// continuous contention, and randomized traffic against a queue-level model.
module tb_regfile_write_arbiter;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Falling-edge register file fed from the DUT write port.
    logic [31:0] rf [32] = '{default: 32'd0};

    always @(negedge clock) begin
        if (bus.wr_en) begin
            rf[bus.wr_addr] <= bus.wr_data;
        end
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_bus;
        logic [31:0] pend;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    task automatic addVec(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic r0, input logic r1,
                          input logic en, input logic [4:0] addr, input logic [31:0] data,
                          input logic chk_bus, input logic [31:0] pend, input logic [15:0] cnt);
        vecs.push_back('{v0, a0, d0, v1, a1, d1, r0, r1, en, addr, data, chk_bus, pend, cnt});
    endtask

    // Each row: inputs for one cycle, readies expected during that cycle,
    // then outputs expected just after the following rising edge.
    task automatic buildVectors();
        // single stream on requester 0
        addVec(1, 3, 32'h11, 0, 0, 0,  1, 1,  0, 0, 32'h0,  1, 32'h8,   0);
        addVec(1, 4, 32'h22, 0, 0, 0,  1, 1,  1, 3, 32'h11, 1, 32'h18,  0);
        addVec(1, 5, 32'h33, 0, 0, 0,  1, 1,  1, 4, 32'h22, 1, 32'h30,  0);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  1, 5, 32'h33, 1, 32'h20,  0);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  0, 5, 32'h33, 1, 32'h0,   0);
        // contention, same-edge tie, requester 0 wins first
        addVec(1, 7, 32'h70, 1, 9, 32'h90, 1, 1, 0, 5, 32'h33, 1, 32'h280, 0);
        addVec(0, 0, 0,      0, 0, 0,  1, 0,  1, 7, 32'h70, 1, 32'h280, 1);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  1, 9, 32'h90, 1, 32'h200, 1);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  0, 9, 32'h90, 1, 32'h0,   1);
        // same-address ordering on r8; second tie goes to requester 1
        addVec(1, 10, 32'h100, 0, 0, 0, 1, 1, 0, 9, 32'h90, 1, 32'h400, 1);
        addVec(1, 11, 32'h110, 1, 8, 32'hAAAA, 1, 1, 1, 10, 32'h100, 1, 32'hD00, 1);
        addVec(1, 8, 32'hBBBB, 0, 0, 0, 0, 1, 1, 8, 32'hAAAA, 1, 32'h900, 2);
        addVec(1, 8, 32'hBBBB, 0, 0, 0, 1, 1, 1, 11, 32'h110, 1, 32'h900, 2);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  1, 8, 32'hBBBB, 1, 32'h100, 2);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  0, 8, 32'hBBBB, 1, 32'h0,   2);
        // write to r0 is accepted but suppressed
        addVec(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 0, 8, 32'hBBBB, 1, 32'h0, 2);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  0, 0, 32'h0,  0, 32'h0,   2);
        addVec(0, 0, 0,      0, 0, 0,  1, 1,  0, 0, 32'h0,  0, 32'h0,   2);
    endtask

    // Reference model: two in-flight entries stamped with the absolute
    // acceptance cycle, plus the currently presented write.
    logic        m_valid [2];
    logic [4:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    logic        m_rr;
    logic        m_en;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_cnt;
    int          m_cycle;

    task automatic modelReset();
        for (int n = 0; n < 2; n++) begin
            m_valid[n] = 1'b0;
            m_addr[n]  = 5'd0;
            m_data[n]  = 32'd0;
            m_stamp[n] = 0;
        end
        m_rr    = 1'b0;
        m_en    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_cnt   = 0;
        m_cycle = 0;
    endtask

    function automatic int modelGrant();
        if (m_valid[0] && m_valid[1]) begin
            if (m_stamp[0] < m_stamp[1]) return 0;
            if (m_stamp[1] < m_stamp[0]) return 1;
            return m_rr ? 1 : 0;
        end
        if (m_valid[0]) return 0;
        if (m_valid[1]) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] modelPending();
        logic [31:0] p;
        p = 32'd0;
        for (int n = 0; n < 2; n++) begin
            if (m_valid[n]) p = p | (32'd1 << m_addr[n]);
        end
        if (m_en) p = p | (32'd1 << m_waddr);
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic modelStep(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                             input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        int   g;
        logic rdy0, rdy1;
        g    = modelGrant();
        rdy0 = !m_valid[0] || (g == 0);
        rdy1 = !m_valid[1] || (g == 1);
        if (m_valid[0] && m_valid[1]) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_stamp[0] == m_stamp[1]) m_rr = !m_rr;
        end
        if (g >= 0) begin
            m_en       = (m_addr[g] != 5'd0);
            m_waddr    = m_addr[g];
            m_wdata    = m_data[g];
            m_valid[g] = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (v0 && rdy0) begin
            m_valid[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_stamp[0] = m_cycle;
        end
        if (v1 && rdy1) begin
            m_valid[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_stamp[1] = m_cycle;
        end
        m_cycle++;
    endtask

    logic        rv0, rv1;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    int          g_exp;
    int          alt_err;
    logic [4:0]  exp_alt;

    // Main test sequence.
    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #12;
        checkOutput("reset_wr_en",   bus.wr_en,        0);
        checkOutput("reset_wr_addr", bus.wr_addr,      0);
        checkOutput("reset_wr_data", bus.wr_data,      0);
        checkOutput("reset_pending", bus.pending,      0);
        checkOutput("reset_cnt",     bus.conflict_cnt, 0);
        checkOutput("reset_ready0",  bus.req0_ready,   1);
        checkOutput("reset_ready1",  bus.req1_ready,   1);
        @(negedge clock);
        reset_n = 1'b1;

        buildVectors();
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            checkOutput($sformatf("vec%0d_ready0", i), bus.req0_ready, vecs[i].r0);
            checkOutput($sformatf("vec%0d_ready1", i), bus.req1_ready, vecs[i].r1);
            applyStimulus(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            @(posedge clock);
            #2;
            checkOutput($sformatf("vec%0d_wr_en", i), bus.wr_en, vecs[i].en);
            if (vecs[i].en || vecs[i].chk_bus) begin
                checkOutput($sformatf("vec%0d_wr_addr", i), bus.wr_addr, vecs[i].addr);
                checkOutput($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].data);
            end
            checkOutput($sformatf("vec%0d_pending", i), bus.pending, vecs[i].pend);
            checkOutput($sformatf("vec%0d_cnt", i), bus.conflict_cnt, vecs[i].cnt);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        checkOutput("rf_r3", rf[3], 32'h11);
        checkOutput("rf_r4", rf[4], 32'h22);
        checkOutput("rf_r5", rf[5], 32'h33);
        checkOutput("rf_r7", rf[7], 32'h70);
        checkOutput("rf_r9", rf[9], 32'h90);
        checkOutput("rf_r8", rf[8], 32'hBBBB);
        checkOutput("rf_r0", rf[0], 32'h0);

        // Reset asserted mid-stream with both holds occupied.
        @(negedge clock);
        applyStimulus(1, 12, 32'hC0, 1, 13, 32'hD0);
        @(negedge clock);
        applyStimulus(1, 14, 32'hE0, 1, 15, 32'hF0);
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midreset_wr_en",   bus.wr_en,        0);
        checkOutput("midreset_pending", bus.pending,      0);
        checkOutput("midreset_cnt",     bus.conflict_cnt, 0);
        checkOutput("midreset_ready0",  bus.req0_ready,   1);
        checkOutput("midreset_ready1",  bus.req1_ready,   1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #2;
            checkOutput($sformatf("postreset%0d_wr_en", k), bus.wr_en, 0);
            checkOutput($sformatf("postreset%0d_pending", k), bus.pending, 0);
        end

        // Both requesters valid continuously: grants alternate 0,1,0,1 and
        // the conflict counter saturates.
        @(negedge clock);
        applyStimulus(1, 1, 32'h1, 1, 2, 32'h2);
        alt_err = 0;
        for (int k = 1; k <= 70000; k++) begin
            @(posedge clock);
            #2;
            if (k >= 2) begin
                exp_alt = ((k % 2) == 0) ? 5'd1 : 5'd2;
                if (!bus.wr_en || bus.wr_addr != exp_alt) alt_err++;
            end
            if (k == 60000) checkOutput("sat_cnt_mid", bus.conflict_cnt, 32'd59999);
        end
        checkOutput("sat_alternation_errors", alt_err, 0);
        checkOutput("sat_cnt_final", bus.conflict_cnt, 32'hFFFF);

        // Randomized traffic against the reference model.
        @(negedge clock);
        applyStimulus(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        modelReset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clock);
            g_exp = modelGrant();
            checkOutput($sformatf("rand%0d_ready0", c), bus.req0_ready, !m_valid[0] || (g_exp == 0));
            checkOutput($sformatf("rand%0d_ready1", c), bus.req1_ready, !m_valid[1] || (g_exp == 1));
            checkOutput($sformatf("rand%0d_wr_en", c), bus.wr_en, m_en);
            checkOutput($sformatf("rand%0d_wr_addr", c), bus.wr_addr, m_waddr);
            checkOutput($sformatf("rand%0d_wr_data", c), bus.wr_data, m_wdata);
            checkOutput($sformatf("rand%0d_pending", c), bus.pending, modelPending());
            checkOutput($sformatf("rand%0d_cnt", c), bus.conflict_cnt, m_cnt);
            rv0 = ($urandom_range(0, 9) < 7);
            rv1 = ($urandom_range(0, 9) < 7);
            ra0 = 5'($urandom_range(0, 7));
            ra1 = 5'($urandom_range(0, 7));
            rd0 = $urandom;
            rd1 = $urandom;
            applyStimulus(rv0, ra0, rd0, rv1, ra1, rd1);
            modelStep(rv0, ra0, rd0, rv1, ra1, rd1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
